// File: rtl/truth_table_checker_pkg.sv
// Purpose : shared state encoding and default parameters for the truth-table checker.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package truth_table_checker_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Defaults sized for the 3-input lab circuits; EXPECTED is majority(A,B,C).
  localparam int         DEF_N_IN     = 3;
  localparam int         DEF_SETTLE   = 4;
  localparam logic [7:0] DEF_EXPECTED = 8'b1110_1000;

endpackage

// File: rtl/tt_settle_counter.sv
// Purpose : counts settle cycles while a vector is held on the DUT inputs.
// Latency : tc is combinational from the count; count updates on each enabled edge.
// Backpressure: none; clear has priority over en.
//
// Ports: clk, reset (async, active-high), clear (sync zero), en (count up),
//        tc (count == SETTLE-1).
module tt_settle_counter #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(SETTLE) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Purpose : sweeps all 2^N_IN input vectors into a combinational DUT and scores its output.
// Latency : SETTLE+1 cycles per vector; done pulses 2^N_IN*(SETTLE+1)+1 cycles after start.
// Backpressure: none; start is ignored outside IDLE.
//
// Ports: clk, reset (async, active-high), start (begin sweep), z_in (DUT output),
//        abc_out (DUT inputs, MSB=A), busy, done (1-cycle pulse), pass,
//        fail_count (mismatches), first_fail (lowest failing vector), obs_vec (observed table).
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                    N_IN     = DEF_N_IN,
  parameter int                    SETTLE   = DEF_SETTLE,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = DEF_EXPECTED
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 z_in,
  output logic [N_IN-1:0]      abc_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        fail_count,
  output logic [N_IN-1:0]      first_fail,
  output logic [(1<<N_IN)-1:0] obs_vec
);

  localparam int NV = 1 << N_IN;

  state_t          state;
  state_t          state_nx;
  logic [N_IN-1:0] idx;
  logic            cnt_clear;
  logic            cnt_en;
  logic            settle_tc;
  logic            mism;
  logic            last;

  tt_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (settle_tc)
  );

  assign mism = z_in ^ EXPECTED[idx];
  assign last = (idx == N_IN'(NV - 1));

  // abc_out only moves when idx moves, i.e. on entry to SETTLE.
  assign abc_out = idx;
  assign busy    = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done    = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_nx  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_en = 1'b1;
        if (settle_tc) begin
          state_nx = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        cnt_clear = 1'b1;
        state_nx  = last ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      pass       <= 1'b0;
      fail_count <= '0;
      first_fail <= '0;
      obs_vec    <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        idx        <= '0;
        pass       <= 1'b0;
        fail_count <= '0;
        first_fail <= '0;
        obs_vec    <= '0;
      end
      if (state == ST_SAMPLE) begin
        obs_vec[idx] <= z_in;
        if (mism) begin
          fail_count <= fail_count + (N_IN+1)'(1);
          if (fail_count == '0) begin
            first_fail <= idx;
          end
        end
        // pass is resolved here, folding in the last vector, so it is
        // already valid in the DONE cycle.
        if (last) begin
          pass <= (fail_count == '0) && !mism;
        end else begin
          idx <= idx + N_IN'(1);
        end
      end
    end
  end

endmodule
